// File: rtl/fetch_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fetch_pkg - shared widths, queue entry type and PC limit. Rev 1.0 |
// +-------------------------------------------------------------------+
package fetch_pkg;

  localparam int D_DEF     = 12;
  localparam int W_DEF     = 9;
  localparam int DEPTH_DEF = 4;

  localparam logic [D_DEF-1:0] PC_MAX = '1;

  typedef struct packed {
    logic [D_DEF-1:0] pc;
    logic [W_DEF-1:0] word;
  } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fetch_fifo - circular buffer of fetched {pc, word} entries. Rev 1.0 |
// +-------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fq_entry_t                push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fq_entry_t                head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     head_q;
  logic [AW-1:0]     tail_q;
  logic [CW-1:0]     count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= push_entry;
  end

  assign head_entry = (count_q != '0) ? mem_q[head_q] : '0;
  assign count      = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fetch_queue - ROM fetch, word queue and redirect handling. Rev 1.0 |
// +-------------------------------------------------------------------+
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int D     = D_DEF,
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  output logic         rom_en,
  output logic [D-1:0] rom_addr,
  input  logic [W-1:0] rom_data,
  output logic         instr_valid,
  output logic [W-1:0] instr,
  output logic [D-1:0] instr_pc,
  input  logic         instr_ready,
  input  logic         redirect,
  input  logic [D-1:0] redirect_target,
  output logic         fetch_done
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [D-1:0]  fpc_q, fpc_d;
  logic [D-1:0]  inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic          done_q, done_d;

  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          pop;
  logic          push;
  fq_entry_t     push_entry;
  fq_entry_t     head_entry;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  assign push        = inflight_q & ~redirect;
  assign push_entry  = '{pc: inflight_pc_q, word: rom_data};

  // A pop this cycle frees a slot, so fetch can resume the cycle ready returns.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign rom_en    = reset & ~redirect & ~done_q & (occupancy < (CW+1)'(DEPTH));
  assign rom_addr  = fpc_q;

  assign instr      = head_entry.word;
  assign instr_pc   = head_entry.pc;
  assign fetch_done = done_q;

  always_comb begin
    fpc_d         = fpc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    done_d        = done_q;
    if (redirect) begin
      fpc_d  = redirect_target;
      done_d = 1'b0;
    end else if (rom_en) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fpc_q;
      if (fpc_q == PC_MAX) done_d = 1'b1;
      else                 fpc_d  = fpc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q         <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      done_q        <= done_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head_entry (head_entry),
    .count      (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_fetch_queue - directed and random fetch/redirect checks. Rev 1.0 |
// +-------------------------------------------------------------------+
module tb_fetch_queue;

  localparam int D     = 12;
  localparam int W     = 9;
  localparam int DEPTH = 4;
  localparam logic [D-1:0] LAST = 12'hFFF;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         rom_en;
  logic [D-1:0] rom_addr;
  logic [W-1:0] rom_data = '0;
  logic         instr_valid;
  logic [W-1:0] instr;
  logic [D-1:0] instr_pc;
  logic         instr_ready = 1'b0;
  logic         redirect = 1'b0;
  logic [D-1:0] redirect_target = '0;
  logic         fetch_done;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected machine state: delivered-in-order queue plus one pending request.
  logic [D+W-1:0] mq[$];
  bit             m_infl = 1'b0;
  logic [D-1:0]   m_ipc  = '0;
  logic [D-1:0]   m_fpc  = '0;
  bit             m_done = 1'b0;

  fetch_queue #(.D(D), .W(W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .rom_en          (rom_en),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_done      (fetch_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rom_word(input logic [D-1:0] a);
    return a[8:0] ^ {a[11:9], a[11:9], a[11:9]};
  endfunction

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_word(rom_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, check outputs, advance model past the rising edge.
  task automatic step(input bit rdy, input bit rd, input logic [D-1:0] tgt);
    bit             pop;
    bit             en;
    int             occ;
    logic [D+W-1:0] head;
    instr_ready     = rdy;
    redirect        = rd;
    redirect_target = tgt;
    #1;
    pop  = (mq.size() != 0) && rdy;
    occ  = mq.size() + int'(m_infl) - int'(pop);
    en   = !rd && !m_done && (occ < DEPTH);
    head = (mq.size() != 0) ? mq[0] : '0;
    chk("rom_en",      32'(rom_en),      32'(en));
    chk("rom_addr",    32'(rom_addr),    32'(m_fpc));
    chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
    chk("instr",       32'(instr),       32'(head[W-1:0]));
    chk("instr_pc",    32'(instr_pc),    32'(head[D+W-1:W]));
    chk("fetch_done",  32'(fetch_done),  32'(m_done));
    if (pop) void'(mq.pop_front());
    if (rd) begin
      mq.delete();
      m_infl = 1'b0;
      m_fpc  = tgt;
      m_done = 1'b0;
    end else begin
      if (m_infl) mq.push_back({m_ipc, rom_word(m_ipc)});
      if (en) begin
        m_infl = 1'b1;
        m_ipc  = m_fpc;
        if (m_fpc == LAST) m_done = 1'b1;
        else               m_fpc  = m_fpc + 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Called at a falling edge: assert reset between edges, release at the next falling edge.
  task automatic mid_reset();
    redirect = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_rom_en",      32'(rom_en),      32'd0);
    chk("rst_rom_addr",    32'(rom_addr),    32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr",       32'(instr),       32'd0);
    chk("rst_instr_pc",    32'(instr_pc),    32'd0);
    chk("rst_fetch_done",  32'(fetch_done),  32'd0);
    mq.delete();
    m_infl = 1'b0;
    m_ipc  = '0;
    m_fpc  = '0;
    m_done = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit           rdy;
    bit           rd;
    logic [D-1:0] tgt;

    @(negedge clk);
    mid_reset();
    repeat (10) step(1'b1, 1'b0, '0);

    // Backpressure from cycle 0, then release.
    mid_reset();
    repeat (7) step(1'b0, 1'b0, '0);
    repeat (3) step(1'b1, 1'b0, '0);

    // Redirect at cycle 5 with a non-empty queue.
    mid_reset();
    repeat (5) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 12'h100);
    repeat (5) step(1'b1, 1'b0, '0);

    // Redirect with pop, and redirect while a request is outstanding.
    step(1'b1, 1'b1, 12'h200);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 12'h300);
    repeat (4) step(1'b1, 1'b0, '0);

    // End of program space, then resume from 0.
    step(1'b1, 1'b1, 12'hFFE);
    repeat (8) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 12'h000);
    repeat (4) step(1'b1, 1'b0, '0);

    // End of program space under backpressure.
    step(1'b0, 1'b1, 12'hFFD);
    repeat (6) step(1'b0, 1'b0, '0);
    repeat (6) step(1'b1, 1'b0, '0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        mid_reset();
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        rd  = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) tgt = 12'hFFC + 12'($urandom_range(0, 3));
        else                           tgt = 12'($urandom);
        step(rdy, rd, tgt);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage between the registered instruction ROM and the control decoder. Generates ROM read addresses from its own fetch counter. Buffers returned 9-bit machine words with their PC in a small FIFO and presents them to decode with a valid/ready handshake. Flushes and restarts on a redirect (taken branch/jump) from the execute side, and reports when sequential fetch has run off the end of program space.

## Interface
Parameters:
- D, 12, program counter width
- W, 9, machine code width
- DEPTH, 4, queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted = 0)
- rom_en  out  1  read request to instruction ROM this cycle
- rom_addr  out  D  ROM read address, valid when rom_en=1
- rom_data  in  W  ROM word for the address requested on the previous cycle (1-cycle read latency)
- instr_valid  out  1  head entry available to decode
- instr  out  W  head machine word
- instr_pc  out  D  address of head machine word
- instr_ready  in  1  decode accepts head this cycle
- redirect  in  1  flush and restart fetch
- redirect_target  in  D  new fetch address, sampled when redirect=1
- fetch_done  out  1  address 2^D-1 has been issued; no further sequential fetch

## Operation
- State:
  - fpc: next fetch address.
  - inflight and inflight_pc: one outstanding ROM request.
  - FIFO: DEPTH entries of {pc, word}.
  - count: FIFO occupancy.
  - done_q: the registered flag driven out as fetch_done.
- pop = instr_valid & instr_ready.
- rom_en = !redirect & !done_q & ((count + inflight − pop) < DEPTH).
  - Combinational; rom_addr = fpc.
- Issue (rom_en=1): the cycle ends with inflight=1, inflight_pc=fpc and fpc=fpc+1.
  - If fpc = 2^D−1, set done_q=1 and do not advance fpc (no wrap to 0).
- Return: if inflight was 1 at the start of a cycle, push {inflight_pc, rom_data} into the FIFO that cycle.
  - The push is suppressed if redirect=1.
- Push and pop in the same cycle are both performed; count unchanged.
- The push/pop rules guarantee no overflow. Pop on an empty FIFO is impossible (instr_valid=0).
- Redirect (priority over all else):
  - A pop in the same cycle still counts as consumed.
  - Then FIFO cleared (count=0) and inflight=0, so the word returning next cycle is never pushed.
  - fpc=redirect_target and done_q=0.
  - No issue in the redirect cycle.
- instr_valid = (count ≠ 0). instr/instr_pc are read from the FIFO head and stay stable while instr_valid=1 and instr_ready=0.
- Reset (async, any time, including mid-stream): fpc=0, count=0, inflight=0, done_q=0.
  - All outputs 0: rom_en, rom_addr, instr_valid, instr, instr_pc, fetch_done.
  - With FIFO empty, instr and instr_pc are forced to 0.

## Timing
- First clock edge after reset release is cycle 0: rom_en=1, rom_addr=0.
- Issue at cycle N → push at N+1 → instr_valid with that word at N+2.
  - Latency 2, throughput 1 word/cycle with instr_ready held high.
- Redirect at cycle R: instr_valid=0 at R+1; rom_en=1 with rom_addr=target at R+1; target word valid at R+3.
- Backpressure: with instr_ready=0, issue stops once count+inflight = DEPTH.
  - With instr_ready returning high at cycle K, rom_en=1 in cycle K (pop credit).
- fetch_done rises the cycle after address 2^D−1 is issued. It stays high until redirect or reset.
  - Queued words continue to drain to decode.

## Structure
- Package fetch_pkg:
  - Defaults for D, W, DEPTH.
  - Typedef fq_entry_t = struct {logic[D-1:0] pc; logic[W-1:0] word}.
  - Constant PC_MAX = 2^D−1.
- Sub-module fetch_fifo: DEPTH-entry circular buffer of fq_entry_t.
  - Ports: push, pop, flush, count.
  - Head/tail pointers of log2(DEPTH) bits wrapping naturally.
  - count is log2(DEPTH)+1 bits.
- fetch_queue holds fpc, inflight, done_q and the issue/redirect logic.

## Test plan
- Reset release, ROM word = low 9 bits of addr, instr_ready=1 → instr_valid at cycle 2; instr_pc 0,1,2… on consecutive cycles, instr matches.
- instr_ready=0 from cycle 0 with DEPTH=4 → rom_en high for 4 cycles (addrs 0–3), then 0. count=4, instr=word@0 held stable. Raise ready → rom_en=1 same cycle, addr 4.
- Redirect to 0x100 at cycle 5 with queue non-empty → instr_valid=0 at cycle 6, rom_addr=0x100 at cycle 6, instr_pc=0x100 at cycle 8. No stale word from addr 4/5 ever appears.
- Redirect coincident with pop, and redirect while a request is in flight → popped word delivered once; in-flight word dropped.
- Redirect to 0xFFE → addrs 0xFFE, 0xFFF issued, then rom_en=0 and fetch_done=1. Both words delivered. A later redirect to 0 clears fetch_done and resumes.
- Assert reset (0) mid-stream between clock edges → all outputs 0 immediately. After release, fetch restarts at addr 0.
